// File: rtl/ram_s1_byte_port.sv
// Byte-wide port onto a 4096x1 synchronous RAM: each byte is moved one bit per cycle.
// Optional clear-all sequencer enabled by defining RAM_S1_PORT_CLEAR_EN.
module ram_s1_byte_port #(
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [8:0]  cmd_addr,
    input  logic [7:0]  cmd_wdata,
    input  logic        clr_req,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic [11:0] ram_addr,
    output logic        ram_di,
    output logic        ram_en,
    output logic        ram_we,
    output logic        ram_rst,
    input  logic        ram_do
);

`ifdef RAM_S1_PORT_CLEAR_EN
    typedef enum logic [2:0] {StIdle, StWr, StRd, StRdl, StClr} state_e;
`else
    typedef enum logic [1:0] {StIdle, StWr, StRd, StRdl} state_e;
`endif

    state_e      state;
    logic [2:0]  cnt;
    logic [2:0]  cnt_nxt;
    logic [8:0]  addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rbuf;
    logic [7:0]  rbuf_nxt;
    logic        do_pend;
    logic [2:0]  prev_j;

    // Bit index inside the byte for a given step of the sequence.
    function automatic logic [2:0] bit_idx(input logic [2:0] step);
        return (LSB_FIRST != 0) ? step : ~step;
    endfunction

    assign cnt_nxt = cnt + 3'd1;
    assign busy    = ~cmd_ready;
    assign ram_rst = 1'b0;

    // RAM_DO reflects the read access issued one edge earlier, tracked by do_pend/prev_j.
    always_comb begin
        rbuf_nxt = rbuf;
        if (do_pend) begin
            rbuf_nxt[prev_j] = ram_do;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            cnt       <= 3'd0;
            addr_q    <= 9'd0;
            wdata_q   <= 8'd0;
            rbuf      <= 8'd0;
            do_pend   <= 1'b0;
            prev_j    <= 3'd0;
            cmd_ready <= 1'b1;
            rd_valid  <= 1'b0;
            rd_data   <= 8'd0;
            ram_addr  <= 12'd0;
            ram_di    <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            do_pend  <= ram_en & ~ram_we;
            prev_j   <= ram_addr[2:0];
            rbuf     <= rbuf_nxt;
            unique case (state)
                StIdle: begin
`ifdef RAM_S1_PORT_CLEAR_EN
                    if (clr_req) begin
                        state     <= StClr;
                        cmd_ready <= 1'b0;
                        ram_addr  <= 12'd0;
                        ram_en    <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_di    <= 1'b0;
                    end else
`endif
                    if (cmd_valid) begin
                        state     <= cmd_wr ? StWr : StRd;
                        cnt       <= 3'd0;
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        cmd_ready <= 1'b0;
                        ram_en    <= 1'b1;
                        ram_we    <= cmd_wr;
                        ram_addr  <= {cmd_addr, bit_idx(3'd0)};
                        ram_di    <= cmd_wr & cmd_wdata[bit_idx(3'd0)];
                    end
                end
                StWr: begin
                    if (cnt == 3'd7) begin
                        state     <= StIdle;
                        cnt       <= 3'd0;
                        cmd_ready <= 1'b1;
                        ram_en    <= 1'b0;
                        ram_we    <= 1'b0;
                        ram_di    <= 1'b0;
                    end else begin
                        cnt      <= cnt_nxt;
                        ram_addr <= {addr_q, bit_idx(cnt_nxt)};
                        ram_di   <= wdata_q[bit_idx(cnt_nxt)];
                    end
                end
                StRd: begin
                    if (cnt == 3'd7) begin
                        state  <= StRdl;
                        cnt    <= 3'd0;
                        ram_en <= 1'b0;
                    end else begin
                        cnt      <= cnt_nxt;
                        ram_addr <= {addr_q, bit_idx(cnt_nxt)};
                    end
                end
                StRdl: begin
                    // Last bit lands this edge; publish the assembled byte.
                    state     <= StIdle;
                    cmd_ready <= 1'b1;
                    rd_valid  <= 1'b1;
                    rd_data   <= rbuf_nxt;
                end
`ifdef RAM_S1_PORT_CLEAR_EN
                StClr: begin
                    if (ram_addr == 12'hfff) begin
                        state     <= StIdle;
                        cmd_ready <= 1'b1;
                        ram_en    <= 1'b0;
                        ram_we    <= 1'b0;
                        ram_addr  <= 12'd0;
                    end else begin
                        ram_addr <= ram_addr + 12'd1;
                    end
                end
`endif
                default: begin
                    state     <= StIdle;
                    cmd_ready <= 1'b1;
                    ram_en    <= 1'b0;
                    ram_we    <= 1'b0;
                    ram_di    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_s1_byte_port.sv
// Bench for ram_s1_byte_port: two instances (LSB_FIRST=0 and 1), each on its own RAM model,
// checked every cycle against a transaction-level model plus directed literal cases.
module tb_ram_s1_byte_port;
    localparam int N = 2;
`ifdef RAM_S1_PORT_CLEAR_EN
    localparam bit ClrEn = 1'b1;
`else
    localparam bit ClrEn = 1'b0;
`endif

    logic        clk;
    logic        rst_n     [N];
    logic        cmd_valid [N];
    logic        cmd_ready [N];
    logic        cmd_wr    [N];
    logic [8:0]  cmd_addr  [N];
    logic [7:0]  cmd_wdata [N];
    logic        clr_req   [N];
    logic        rd_valid  [N];
    logic [7:0]  rd_data   [N];
    logic        busy      [N];
    logic [11:0] ram_addr  [N];
    logic        ram_di    [N];
    logic        ram_en    [N];
    logic        ram_we    [N];
    logic        ram_rst   [N];
    logic        ram_do    [N];

    logic        mem    [N][4096];
    logic        shadow [N][4096];
    int          checks = 0;
    int          errors = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        ram_s1_byte_port #(.LSB_FIRST(g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .cmd_valid (cmd_valid[g]),
            .cmd_ready (cmd_ready[g]),
            .cmd_wr    (cmd_wr[g]),
            .cmd_addr  (cmd_addr[g]),
            .cmd_wdata (cmd_wdata[g]),
            .clr_req   (clr_req[g]),
            .rd_valid  (rd_valid[g]),
            .rd_data   (rd_data[g]),
            .busy      (busy[g]),
            .ram_addr  (ram_addr[g]),
            .ram_di    (ram_di[g]),
            .ram_en    (ram_en[g]),
            .ram_we    (ram_we[g]),
            .ram_rst   (ram_rst[g]),
            .ram_do    (ram_do[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // RAMB4_S1-style single-port RAM, write-first output.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (ram_en[k]) begin
                if (ram_rst[k]) ram_do[k] <= 1'b0;
                else if (ram_we[k]) ram_do[k] <= ram_di[k];
                else ram_do[k] <= mem[k][ram_addr[k]];
                if (ram_we[k]) mem[k][ram_addr[k]] <= ram_di[k];
            end
        end
    end

    // Inputs as seen by the DUT at each rising edge.
    logic       s_rst [N];
    logic       s_cv  [N];
    logic       s_wr  [N];
    logic       s_clr [N];
    logic [8:0] s_addr[N];
    logic [7:0] s_wd  [N];
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            s_rst[k]  <= rst_n[k];
            s_cv[k]   <= cmd_valid[k];
            s_wr[k]   <= cmd_wr[k];
            s_clr[k]  <= clr_req[k];
            s_addr[k] <= cmd_addr[k];
            s_wd[k]   <= cmd_wdata[k];
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %0h, want %0h", name, k, $time, act, exp);
        end
    endtask

    // Transaction-level model: op kind plus edges elapsed since it started.
    typedef enum logic [1:0] {OpIdle, OpWr, OpRd, OpClr} op_e;
    op_e        m_op  [N];
    int         m_n   [N];
    logic [8:0] m_addr[N];
    logic [7:0] m_wd  [N];
    logic       m_rv  [N];
    logic [7:0] m_rd  [N];

    function automatic logic [2:0] jmap(input int k, input int n);
        logic [2:0] t;
        t = 3'(n);
        return (k == 1) ? t : 3'(7 - n);
    endfunction

    function automatic logic [7:0] byte_of(input int k, input logic [8:0] a);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = shadow[k][{a, 3'(b)}];
        return v;
    endfunction

    task automatic model_reset(input int k);
        m_op[k] = OpIdle;
        m_n[k]  = 0;
        m_rv[k] = 1'b0;
        m_rd[k] = 8'h00;
    endtask

    always @(negedge clk) begin
        logic        e_en;
        logic        e_we;
        logic        e_di;
        logic [11:0] e_addr;
        for (int k = 0; k < N; k++) begin
            m_rv[k] = 1'b0;
            if (!s_rst[k]) begin
                model_reset(k);
            end else if (m_op[k] == OpIdle) begin
                if (ClrEn && s_clr[k]) begin
                    m_op[k] = OpClr;
                    m_n[k]  = 0;
                end else if (s_cv[k]) begin
                    m_op[k]   = s_wr[k] ? OpWr : OpRd;
                    m_n[k]    = 0;
                    m_addr[k] = s_addr[k];
                    m_wd[k]   = s_wd[k];
                end
            end else begin
                m_n[k]++;
                case (m_op[k])
                    OpWr: begin
                        shadow[k][{m_addr[k], jmap(k, m_n[k] - 1)}] = m_wd[k][jmap(k, m_n[k] - 1)];
                        if (m_n[k] == 8) m_op[k] = OpIdle;
                    end
                    OpRd: begin
                        if (m_n[k] == 9) begin
                            m_rv[k] = 1'b1;
                            m_rd[k] = byte_of(k, m_addr[k]);
                            m_op[k] = OpIdle;
                        end
                    end
                    OpClr: begin
                        shadow[k][m_n[k] - 1] = 1'b0;
                        if (m_n[k] == 4096) m_op[k] = OpIdle;
                    end
                    default: m_op[k] = OpIdle;
                endcase
            end
            if (!rst_n[k]) model_reset(k);

            e_en = 1'b0;
            e_we = 1'b0;
            e_di = 1'b0;
            e_addr = 12'd0;
            case (m_op[k])
                OpWr: begin
                    e_en = 1'b1;
                    e_we = 1'b1;
                    e_addr = {m_addr[k], jmap(k, m_n[k])};
                    e_di = m_wd[k][jmap(k, m_n[k])];
                end
                OpRd: begin
                    if (m_n[k] < 8) begin
                        e_en = 1'b1;
                        e_addr = {m_addr[k], jmap(k, m_n[k])};
                    end
                end
                OpClr: begin
                    e_en = 1'b1;
                    e_we = 1'b1;
                    e_addr = 12'(m_n[k]);
                end
                default: ;
            endcase
            chk("cmd_ready", k, cmd_ready[k], m_op[k] == OpIdle);
            chk("busy", k, busy[k], m_op[k] != OpIdle);
            chk("ram_en", k, ram_en[k], e_en);
            chk("ram_we", k, ram_we[k], e_we);
            chk("ram_di", k, ram_di[k], e_di);
            chk("ram_rst", k, ram_rst[k], 1'b0);
            if (e_en) chk("ram_addr", k, ram_addr[k], e_addr);
            chk("rd_valid", k, rd_valid[k], m_rv[k]);
            chk("rd_data", k, rd_data[k], m_rd[k]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs(input int k);
        cmd_valid[k] = 1'b0;
        cmd_wr[k]    = 1'b0;
        cmd_addr[k]  = 9'd0;
        cmd_wdata[k] = 8'd0;
        clr_req[k]   = 1'b0;
    endtask

    task automatic wait_ready(input int k, input int limit);
        int n;
        n = 0;
        while (cmd_ready[k] !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        if (cmd_ready[k] !== 1'b1) chk("wait_ready_timeout", k, cmd_ready[k], 1);
    endtask

    task automatic issue(input int k, input bit wr, input logic [8:0] a, input logic [7:0] d);
        wait_ready(k, 5000);
        cmd_valid[k] = 1'b1;
        cmd_wr[k]    = wr;
        cmd_addr[k]  = a;
        cmd_wdata[k] = d;
        tick();
        cmd_valid[k] = 1'b0;
    endtask

    // Edges from acceptance until rd_valid, or limit+1 on timeout.
    task automatic wait_rd(input int k, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (rd_valid[k] !== 1'b1 && n <= 20);
    endtask

    initial begin
        logic [7:0]  pat;
        int          n;
        int unsigned ridx;
        logic        rwr;
        bit          written[N][16];

        for (int k = 0; k < N; k++) begin
            rst_n[k] = 1'b0;
            idle_inputs(k);
            for (int i = 0; i < 16; i++) written[k][i] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 1, cmd_ready[1], 1);
        chk("rst_rd_data", 1, rd_data[1], 0);
        chk("rst_ram_addr", 1, ram_addr[1], 0);
        chk("rst_ram_en", 1, ram_en[1], 0);
        tick();
        for (int k = 0; k < N; k++) rst_n[k] = 1'b1;
        tick();

        // Write 0xA5 to 0x005, LSB first.
        pat = 8'hA5;
        issue(1, 1'b1, 9'h005, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            chk("wr_addr", 1, ram_addr[1], 12'h028 + 12'(i));
            chk("wr_di", 1, ram_di[1], pat[i]);
            chk("wr_ready_low", 1, cmd_ready[1], 0);
            tick();
        end
        chk("wr_ready_back", 1, cmd_ready[1], 1);

        issue(1, 1'b0, 9'h005, 8'h00);
        wait_rd(1, n);
        chk("rd_latency", 1, n, 9);
        chk("rd_byte_a5", 1, rd_data[1], 8'hA5);
        chk("rd_ready_same", 1, cmd_ready[1], 1);

        // MSB-first instance: 0x3C at 0x1FF.
        pat = 8'h3C;
        issue(0, 1'b1, 9'h1FF, 8'h3C);
        for (int i = 0; i < 8; i++) begin
            chk("msb_addr", 0, ram_addr[0], 12'hFFF - 12'(i));
            chk("msb_di", 0, ram_di[0], pat[7 - i]);
            tick();
        end
        issue(0, 1'b0, 9'h1FF, 8'h00);
        wait_rd(0, n);
        chk("msb_rd_byte", 0, rd_data[0], 8'h3C);

        // Back-to-back: valid held through a write then a read.
        wait_ready(1, 50);
        cmd_valid[1] = 1'b1;
        cmd_wr[1]    = 1'b1;
        cmd_addr[1]  = 9'h010;
        cmd_wdata[1] = 8'h11;
        tick();
        cmd_wr[1] = 1'b0;
        n = 0;
        while (cmd_ready[1] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("b2b_write_len", 1, n, 8);
        tick();
        chk("b2b_accept_ready", 1, cmd_ready[1], 0);
        chk("b2b_accept_en", 1, ram_en[1], 1);
        chk("b2b_accept_addr", 1, ram_addr[1], 12'h080);
        cmd_valid[1] = 1'b0;
        n = 0;
        while (rd_valid[1] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("b2b_rd_byte", 1, rd_data[1], 8'h11);

        // Reset mid-write: bits 0..3 new, 4..7 old.
        issue(1, 1'b1, 9'h0AA, 8'h5A);
        issue(1, 1'b1, 9'h0AA, 8'hC3);
        repeat (4) tick();
        rst_n[1] = 1'b0;
        #1;
        chk("arst_en", 1, ram_en[1], 0);
        chk("arst_we", 1, ram_we[1], 0);
        chk("arst_ready", 1, cmd_ready[1], 1);
        tick();
        rst_n[1] = 1'b1;
        tick();
        chk("arst_ready_after", 1, cmd_ready[1], 1);
        issue(1, 1'b0, 9'h0AA, 8'h00);
        wait_rd(1, n);
        chk("arst_rd_byte", 1, rd_data[1], 8'h53);

        // Clear request together with a write command.
        wait_ready(1, 50);
        clr_req[1]   = 1'b1;
        cmd_valid[1] = 1'b1;
        cmd_wr[1]    = 1'b1;
        cmd_addr[1]  = 9'h005;
        cmd_wdata[1] = 8'h77;
        tick();
        clr_req[1] = 1'b0;
`ifdef RAM_S1_PORT_CLEAR_EN
        chk("clr_start_addr", 1, ram_addr[1], 12'h000);
        chk("clr_start_we", 1, ram_we[1], 1);
        n = 0;
        while (cmd_ready[1] !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        chk("clr_len", 1, n, 4096);
        tick();
`endif
        chk("cmd_after_clr_ready", 1, cmd_ready[1], 0);
        chk("cmd_after_clr_we", 1, ram_we[1], 1);
        chk("cmd_after_clr_addr", 1, ram_addr[1], 12'h028);
        cmd_valid[1] = 1'b0;
        issue(1, 1'b0, 9'h0AA, 8'h00);
        wait_rd(1, n);
        chk("rd_after_clr", 1, rd_data[1], ClrEn ? 8'h00 : 8'h53);

        // Random traffic on both instances.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int k = 0; k < N; k++) begin
                rst_n[k] = ($urandom_range(0, 299) != 0);
                ridx = $urandom_range(0, 15);
                rwr = 1'($urandom_range(0, 1));
                if (!written[k][ridx]) rwr = 1'b1;
                cmd_valid[k] = ($urandom_range(0, 3) != 0);
                cmd_wr[k]    = rwr;
                cmd_addr[k]  = 9'((ridx * 37 + 3) % 512);
                cmd_wdata[k] = 8'($urandom);
                clr_req[k]   = ClrEn ? 1'b0 : 1'($urandom_range(0, 1));
                if (rst_n[k] && cmd_valid[k] && cmd_ready[k] && rwr) written[k][ridx] = 1'b1;
            end
            tick();
        end
        for (int k = 0; k < N; k++) begin
            idle_inputs(k);
            rst_n[k] = 1'b1;
        end
        for (int k = 0; k < N; k++) wait_ready(k, 50);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
